// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port line-memory arbiter and the caches it serves.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        cache_data_type    data;
        logic              rw;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
        logic           err;
    } mem_data_type;

    // On a tie the port that was not served last wins; otherwise whoever is pending.
    function automatic logic rr_pick(input logic [1:0] pend, input logic last_grant);
        if (&pend) return ~last_grant;
        return pend[1];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W,
    parameter int LINE_W = mem_port_arbiter_pkg::LINE_W
);
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [LINE_W-1:0] p0_data, p1_data;
    logic              p0_rw, p1_rw, p0_valid, p1_valid;
    logic [LINE_W-1:0] p0_rdata, p1_rdata;
    logic              p0_ready, p1_ready, p0_err, p1_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic              mem_rw, mem_valid, mem_ready;
    logic [1:0]        dbg_ovf;

    modport slave (
        input  p0_addr, p1_addr, p0_data, p1_data, p0_rw, p1_rw, p0_valid, p1_valid,
        input  mem_rdata, mem_ready,
        output p0_rdata, p1_rdata, p0_ready, p1_ready, p0_err, p1_err,
        output mem_addr, mem_wdata, mem_rw, mem_valid, dbg_ovf
    );

    modport master (
        output p0_addr, p1_addr, p0_data, p1_data, p0_rw, p1_rw, p0_valid, p1_valid,
        output mem_rdata, mem_ready,
        input  p0_rdata, p1_rdata, p0_ready, p1_ready, p0_err, p1_err,
        input  mem_addr, mem_wdata, mem_rw, mem_valid, dbg_ovf
    );
endinterface

// File: rtl/mem_port_arbiter_req_latch.sv
// Per-port request holder: pending flag, captured request fields and a sticky overflow flag.
module arb_req_latch import mem_port_arbiter_pkg::*; #(
    parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W,
    parameter int LINE_W = mem_port_arbiter_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LINE_W-1:0] data_in,
    input  logic              rw_in,
    input  logic              clr,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [LINE_W-1:0] data,
    output logic              rw,
    output logic              ovf
);
    logic              pend_q, pend_d, ovf_q, ovf_d, rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        addr_d = addr_q;
        data_d = data_q;
        rw_d   = rw_q;
        if (clr) pend_d = 1'b0;
        // A pulse landing in the clearing cycle wins, so a back-to-back request is not lost.
        if (valid && (!pend_q || clr)) begin
            pend_d = 1'b1;
            addr_d = addr_in;
            data_d = data_in;
            rw_d   = rw_in;
        end else if (valid) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            addr_q <= addr_d;
            data_q <= data_d;
            rw_q   <= rw_d;
        end
    end

    assign pend = pend_q;
    assign addr = addr_q;
    assign data = data_q;
    assign rw   = rw_q;
    assign ovf  = ovf_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (I-cache/D-cache) arbiter for one line memory port with watchdog error completion.
// ARB_FIXED_PRIO_EN: port 1 always wins ties; otherwise round-robin.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int ADDR_W      = mem_port_arbiter_pkg::ADDR_W,
    parameter int LINE_W      = mem_port_arbiter_pkg::LINE_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_type;

    localparam int              CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              WDOG_EN = (TIMEOUT_CYC != 0);

    logic [1:0]             req_valid, req_rw_in, req_rw, pend, clr, ovf;
    logic [1:0][ADDR_W-1:0] req_addr_in, req_addr;
    logic [1:0][LINE_W-1:0] req_data_in, req_data;

    assign req_valid   = {bus.p1_valid, bus.p0_valid};
    assign req_rw_in   = {bus.p1_rw, bus.p0_rw};
    assign req_addr_in = {bus.p1_addr, bus.p0_addr};
    assign req_data_in = {bus.p1_data, bus.p0_data};

    for (genvar i = 0; i < 2; i++) begin : g_lat
        arb_req_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_lat (
            .clk(clk), .rst(rst), .valid(req_valid[i]), .addr_in(req_addr_in[i]),
            .data_in(req_data_in[i]), .rw_in(req_rw_in[i]), .clr(clr[i]),
            .pend(pend[i]), .addr(req_addr[i]), .data(req_data[i]), .rw(req_rw[i]), .ovf(ovf[i])
        );
    end

    arb_state_type          state_q, state_d;
    logic                   grant_q, grant_d, last_grant_q, last_grant_d, grant_pick;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [1:0][LINE_W-1:0] rdata_q, rdata_d;
    logic [1:0]             ready_q, ready_d, err_q, err_d;

`ifdef ARB_FIXED_PRIO_EN
    assign grant_pick = pend[1];
`else
    assign grant_pick = rr_pick(pend, last_grant_q);
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_valid_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rw_d     = mem_rw_q;
        rdata_d      = '0;
        ready_d      = '0;
        err_d        = '0;
        clr          = '0;
        unique case (state_q)
            IDLE: if (|pend) begin
                state_d     = ISSUE;
                grant_d     = grant_pick;
                cnt_d       = '0;
                mem_valid_d = 1'b1;
                mem_addr_d  = req_addr[grant_pick];
                mem_wdata_d = req_data[grant_pick];
                mem_rw_d    = req_rw[grant_pick];
            end
            // Watchdog runs from the issue cycle, so an error lands TIMEOUT_CYC cycles after mem_valid.
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = cnt_q + 1'b1;
            end
            WAIT: if (bus.mem_ready) begin
                state_d           = RESP;
                ready_d[grant_q]  = 1'b1;
                rdata_d[grant_q]  = bus.mem_rdata;
            end else if (WDOG_EN && cnt_q >= TO_LAST) begin
                state_d           = RESP;
                ready_d[grant_q]  = 1'b1;
                err_d[grant_q]    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                clr[grant_q] = 1'b1;
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rw_q     <= 1'b0;
            rdata_q      <= '0;
            ready_q      <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_q     <= mem_rw_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.p0_rdata  = rdata_q[0];
    assign bus.p1_rdata  = rdata_q[1];
    assign bus.p0_ready  = ready_q[0];
    assign bus.p1_ready  = ready_q[1];
    assign bus.p0_err    = err_q[0];
    assign bus.p1_err    = err_q[1];
    assign bus.dbg_ovf   = ovf;
endmodule
